idli_uart_m: RTL

//  UART peer of the EX unit's nibble-wide UART interface. TX side: assembles 4b nibbles from EX into bytes
//  (low nibble first), queues them, serialises 8N1 on o_uart_tx. RX side: deserialises 8N1 from i_uart_rx,

---
 rtl/idli_pkg.sv | 28 ++
 rtl/idli_uart_fifo_m.sv | 52 +++++
 rtl/idli_uart_m.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
`default_nettype none
// ============================================================================
// idli_pkg
// Shared types for the idli UART peer: FSM state encodings and byte type.
// Revision: 1.0
// ============================================================================
package idli_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_rx_state_t;

    typedef logic [7:0] uart_byte_t;

    localparam int unsigned UART_DATA_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/idli_uart_fifo_m.sv
`default_nettype none
// ============================================================================
// idli_uart_fifo_m
// Byte FIFO with registered pointers; head is read combinationally.
// Revision: 1.0
// ============================================================================
module idli_uart_fifo_m
    import idli_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  uart_byte_t push_data,
    input  logic       pop,
    output uart_byte_t pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    uart_byte_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/idli_uart_m.sv
`default_nettype none
// ============================================================================
// idli_uart_m
// Nibble-wide UART peer for the EX unit: nibble->byte TX path, byte->nibble RX path, 8N1 serial.
// Revision: 1.0
// ============================================================================
module idli_uart_m
    import idli_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_uart_gck,
    input  logic       i_uart_rst_n,
    input  logic [3:0] i_uart_tx_data,
    input  logic       i_uart_tx_vld,
    output logic [3:0] o_uart_rx_data,
    output logic       o_uart_rx_vld,
    input  logic       i_uart_rx_acp,
    output logic       o_uart_tx,
    input  logic       i_uart_rx,
    output logic       o_uart_tx_ovf,
    output logic       o_uart_rx_ovf,
    output logic       o_uart_rx_ferr
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    // ------------------------------------------------------------------------
    // TX nibble assembly
    // ------------------------------------------------------------------------
    logic       tx_phase;
    logic [3:0] tx_lo;
    logic       asm_vld;
    uart_byte_t asm_byte;

    always_ff @(posedge i_uart_gck) begin
        if (!i_uart_rst_n) begin
            tx_phase <= 1'b0;
            tx_lo    <= '0;
            asm_vld  <= 1'b0;
            asm_byte <= '0;
        end else begin
            asm_vld <= 1'b0;
            if (i_uart_tx_vld) begin
                tx_phase <= ~tx_phase;
                if (!tx_phase) begin
                    tx_lo <= i_uart_tx_data;
                end else begin
                    asm_vld  <= 1'b1;
                    asm_byte <= {i_uart_tx_data, tx_lo};
                end
            end
        end
    end

    logic       tx_pop;
    logic       tx_full;
    logic       tx_empty;
    uart_byte_t tx_head;

    idli_uart_fifo_m #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (i_uart_gck),
        .rst_n     (i_uart_rst_n),
        .push      (asm_vld),
        .push_data (asm_byte),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // ------------------------------------------------------------------------
    // TX serialiser
    // ------------------------------------------------------------------------
    uart_tx_state_t   tx_state;
    uart_tx_state_t   tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    uart_byte_t       tx_shift;
    logic             tx_tick;
    logic             tx_line_nxt;

    assign tx_tick = (tx_cnt == BIT_LAST);

    always_ff @(posedge i_uart_gck) begin
        if (!i_uart_rst_n) tx_state <= TX_IDLE;
        else               tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop       = 1'b1;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: if (tx_tick) tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == LAST_BIT) tx_state_nxt = TX_STOP;
            TX_STOP: begin
                // Chain straight into the next frame when a byte is waiting.
                if (tx_tick) begin
                    if (!tx_empty) begin
                        tx_pop       = 1'b1;
                        tx_state_nxt = TX_START;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_line_nxt = o_uart_tx;
        unique case (tx_state)
            TX_IDLE:  tx_line_nxt = !tx_pop;
            TX_START: if (tx_tick) tx_line_nxt = tx_shift[0];
            TX_DATA:  if (tx_tick) tx_line_nxt = (tx_bit == LAST_BIT) ? 1'b1 : tx_shift[1];
            TX_STOP:  if (tx_tick) tx_line_nxt = !tx_pop;
            default:  tx_line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge i_uart_gck) begin
        if (!i_uart_rst_n) begin
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            o_uart_tx <= 1'b1;
        end else begin
            o_uart_tx <= tx_line_nxt;
            tx_cnt    <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + CNT_W'(1);
            if (tx_state != TX_DATA) tx_bit <= '0;
            else if (tx_tick)        tx_bit <= tx_bit + 3'd1;
            if (tx_pop)                             tx_shift <= tx_head;
            else if (tx_state == TX_DATA && tx_tick) tx_shift <= tx_shift >> 1;
        end
    end

    // ------------------------------------------------------------------------
    // RX synchroniser and deserialiser
    // ------------------------------------------------------------------------
    logic [1:0]       rx_sync;
    logic             rx_s;
    uart_rx_state_t   rx_state;
    uart_rx_state_t   rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    uart_byte_t       rx_shift;
    logic             rx_half_tick;
    logic             rx_full_tick;
    logic             rx_push;
    logic             rx_ferr_set;

    assign rx_s         = rx_sync[1];
    assign rx_half_tick = (rx_cnt == HALF_LAST);
    assign rx_full_tick = (rx_cnt == BIT_LAST);

    always_ff @(posedge i_uart_gck) begin
        if (!i_uart_rst_n) rx_sync <= 2'b11;
        else               rx_sync <= {rx_sync[0], i_uart_rx};
    end

    always_ff @(posedge i_uart_gck) begin
        if (!i_uart_rst_n) rx_state <= RX_IDLE;
        else               rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (!rx_s) rx_state_nxt = RX_START;
            // A start bit that has gone high again by mid-bit is treated as noise.
            RX_START: if (rx_half_tick) rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_full_tick && rx_bit == LAST_BIT) rx_state_nxt = RX_STOP;
            RX_STOP:  if (rx_full_tick) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_push     = (rx_state == RX_STOP) && rx_full_tick && rx_s;
        rx_ferr_set = (rx_state == RX_STOP) && rx_full_tick && !rx_s;
    end

    always_ff @(posedge i_uart_gck) begin
        if (!i_uart_rst_n) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state == RX_IDLE || (rx_state == RX_START && rx_half_tick) || rx_full_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + CNT_W'(1);
            if (rx_state != RX_DATA) rx_bit <= '0;
            else if (rx_full_tick)   rx_bit <= rx_bit + 3'd1;
            if (rx_state == RX_DATA && rx_full_tick)
                rx_shift <= {rx_s, rx_shift[7:1]};
        end
    end

    // ------------------------------------------------------------------------
    // RX FIFO and nibble presentation
    // ------------------------------------------------------------------------
    logic       rx_pop;
    logic       rx_full;
    logic       rx_empty;
    uart_byte_t rx_head;
    logic       rx_phase;

    idli_uart_fifo_m #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (i_uart_gck),
        .rst_n     (i_uart_rst_n),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign rx_pop         = i_uart_rx_acp && !rx_empty && rx_phase;
    assign o_uart_rx_vld  = !rx_empty;
    assign o_uart_rx_data = rx_empty ? 4'h0 : (rx_phase ? rx_head[7:4] : rx_head[3:0]);

    always_ff @(posedge i_uart_gck) begin
        if (!i_uart_rst_n)                     rx_phase <= 1'b0;
        else if (i_uart_rx_acp && !rx_empty)   rx_phase <= ~rx_phase;
    end

    // ------------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------------
    always_ff @(posedge i_uart_gck) begin
        if (!i_uart_rst_n) begin
            o_uart_tx_ovf  <= 1'b0;
            o_uart_rx_ovf  <= 1'b0;
            o_uart_rx_ferr <= 1'b0;
        end else begin
            if (asm_vld && tx_full && !tx_pop) o_uart_tx_ovf  <= 1'b1;
            if (rx_push && rx_full && !rx_pop) o_uart_rx_ovf  <= 1'b1;
            if (rx_ferr_set)                   o_uart_rx_ferr <= 1'b1;
        end
    end

endmodule
`default_nettype wire
